// File: rtl/fifo_uart_tx.sv
// UART transmitter fed by an upstream FIFO with registered read data.
// Frames are start bit, WIDTH data bits LSB-first, optional parity bit and stop bit(s).
module fifo_uart_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             tx_en,
    input  logic             fifo_valid,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = $clog2(WIDTH);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic              HAS_PAR   = 1'(PARITY != 0);
    localparam logic              ODD_PAR   = 1'(PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              stop_q, stop_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              baud_end;
    logic              fetch_ok;

    // Next-state and counter logic; the baud counter restarts on every bit boundary.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        par_d    = par_q;
        baud_end = (baud_q == BAUD_LAST);
        fetch_ok = tx_en && fifo_valid;

        unique case (state_q)
            S_IDLE: begin
                if (fetch_ok) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = fifo_data;
                par_d   = (^fifo_data) ^ ODD_PAR;
                baud_d  = '0;
                idx_d   = '0;
                stop_d  = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    if (stop_q == STOP_LAST) begin
                        stop_d  = 1'b0;
                        state_d = fetch_ok ? S_REQ : S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values are derived from the next state so the registered outputs line up with state_q.
    always_comb begin
        tx_d         = 1'b1;
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (stop_d == STOP_LAST);

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            idx_q        <= '0;
            stop_q       <= 1'b0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            idx_q        <= idx_d;
            stop_q       <= stop_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Read strobe is a pure decode of the registered state.
    assign fifo_rd_en = (state_q == S_REQ);
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: three frame formats share one word plan;
// each line monitor rebuilds the expected bit sequence from the word and checks timing.
module tb_fifo_uart_tx;

    localparam int N       = 3;
    localparam int MAX_CYC = 3000;

    function automatic int cfg_w(input int i);
        return (i == 2) ? 5 : 8;
    endfunction
    function automatic int cfg_cpb(input int i);
        return (i == 2) ? 3 : 4;
    endfunction
    function automatic int cfg_par(input int i);
        return i;
    endfunction
    function automatic int cfg_stop(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    logic clk   = 1'b0;
    logic nrst  = 1'b0;
    logic tx_en = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [8:0] plan[$];

    logic tx_v[N];
    logic busy_v[N];
    logic rd_v[N];
    logic fd_v[N];
    logic fv_v[N];
    int   rd_cnt[N];
    int   rd_empty[N];
    int   frames_ok[N];
    int   dropped[N];
    int   gap[N];

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int W     = cfg_w(gi);
        localparam int CPB   = cfg_cpb(gi);
        localparam int PAR   = cfg_par(gi);
        localparam int STOP  = cfg_stop(gi);
        localparam int NBITS = 1 + W + ((PAR != 0) ? 1 : 0) + STOP;
        localparam int FLEN  = NBITS * CPB;

        logic         fv    = 1'b0;
        logic [W-1:0] fdata = '0;
        logic         rd;
        logic         txl;
        logic         bsy;
        logic         fd;
        logic [W-1:0] fq[$];
        int           acc   = 0;

        fifo_uart_tx #(
            .WIDTH       (W),
            .CLKS_PER_BIT(CPB),
            .PARITY      (PAR),
            .STOP_BITS   (STOP)
        ) u_dut (
            .clk       (clk),
            .nrst      (nrst),
            .tx_en     (tx_en),
            .fifo_valid(fv),
            .fifo_data (fdata),
            .fifo_rd_en(rd),
            .tx        (txl),
            .busy      (bsy),
            .frame_done(fd)
        );

        assign tx_v[gi]   = txl;
        assign busy_v[gi] = bsy;
        assign rd_v[gi]   = rd;
        assign fd_v[gi]   = fd;
        assign fv_v[gi]   = fv;

        // Upstream FIFO: one-cycle read latency, garbage on the data bus in every other cycle.
        always @(posedge clk) begin
            while (acc < plan.size()) begin
                fq.push_back(plan[acc][W-1:0]);
                acc++;
            end
            if (rd) begin
                rd_cnt[gi]++;
                if (fq.size() != 0) begin
                    fdata <= fq.pop_front();
                end else begin
                    rd_empty[gi]++;
                    fdata <= W'($urandom);
                end
            end else begin
                fdata <= W'($urandom);
            end
            fv <= (fq.size() != 0) && !(rd && fq.size() == 1);
        end

        // Line monitor: decodes each frame and compares it against the next planned word.
        initial begin : mon
            int           idle_run;
            int           exp_idx;
            int           cyc;
            int           good;
            int           fd_at;
            int           fd_n;
            int           busy_n;
            bit           aborted;
            logic [W-1:0] w;
            logic [NBITS-1:0] seq;
            idle_run = 0;
            exp_idx  = 0;
            forever begin
                @(negedge clk);
                if (!nrst) begin
                    idle_run = 0;
                end else if (txl) begin
                    idle_run++;
                    if (fd) chk($sformatf("dut%0d frame_done outside frame", gi), 1, 0);
                end else begin
                    gap[gi] = idle_run;
                    chk($sformatf("dut%0d frame expected", gi), (exp_idx < plan.size()) ? 1 : 0, 1);
                    w = (exp_idx < plan.size()) ? plan[exp_idx][W-1:0] : '0;
                    exp_idx++;
                    seq    = '1;
                    seq[0] = 1'b0;
                    for (int k = 0; k < W; k++) seq[1+k] = w[k];
                    if (PAR != 0) seq[1+W] = (^w) ^ (PAR == 2);
                    cyc     = 0;
                    fd_at   = 0;
                    fd_n    = 0;
                    busy_n  = 0;
                    aborted = 1'b0;
                    for (int b = 0; b < NBITS && !aborted; b++) begin
                        good = 0;
                        for (int c = 0; c < CPB && !aborted; c++) begin
                            if (cyc != 0) @(negedge clk);
                            if (!nrst) begin
                                aborted = 1'b1;
                            end else begin
                                cyc++;
                                if (txl == seq[b]) good++;
                                if (bsy) busy_n++;
                                if (fd) begin
                                    fd_n++;
                                    fd_at = cyc;
                                end
                            end
                        end
                        if (!aborted)
                            chk($sformatf("dut%0d word %0h bit %0d cycles", gi, w, b), good, CPB);
                    end
                    idle_run = 0;
                    if (aborted) begin
                        dropped[gi]++;
                    end else begin
                        chk($sformatf("dut%0d busy cycles", gi), busy_n, FLEN);
                        chk($sformatf("dut%0d frame_done count", gi), fd_n, 1);
                        chk($sformatf("dut%0d frame_done cycle", gi), fd_at, FLEN);
                        frames_ok[gi]++;
                    end
                end
            end
        end
    end

    function automatic bit all_idle();
        for (int i = 0; i < N; i++) begin
            if (busy_v[i] || fv_v[i] || rd_v[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push(input logic [8:0] w);
        @(posedge clk);
        #2;
        plan.push_back(w);
    endtask

    task automatic drive_en(input logic v);
        @(posedge clk);
        #2;
        tx_en = v;
    endtask

    task automatic wait_idle(input string name);
        int n;
        int quiet;
        n     = 0;
        quiet = 0;
        while (quiet < 3 && n < MAX_CYC) begin
            @(negedge clk);
            n++;
            quiet = all_idle() ? quiet + 1 : 0;
        end
        chk({name, " drained in budget"}, (quiet >= 3) ? 1 : 0, 1);
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_v[0] && n < 200);
        chk({name, " start bit seen"}, tx_v[0] ? 0 : 1, 1);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin : main
        int bad[N];
        int rd0[N];
        int fr0[N];
        int dr0[N];
        int n;

        nrst  = 1'b0;
        tx_en = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("dut%0d reset tx", i), int'(tx_v[i]), 1);
            chk($sformatf("dut%0d reset busy", i), int'(busy_v[i]), 0);
            chk($sformatf("dut%0d reset rd_en", i), int'(rd_v[i]), 0);
            chk($sformatf("dut%0d reset frame_done", i), int'(fd_v[i]), 0);
        end
        @(posedge clk);
        #2;
        nrst = 1'b1;

        // Enabled but nothing queued: line stays idle and no reads happen.
        drive_en(1'b1);
        for (int i = 0; i < N; i++) bad[i] = 0;
        repeat (100) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (tx_v[i] !== 1'b1 || busy_v[i] || rd_v[i]) bad[i]++;
        end
        for (int i = 0; i < N; i++) chk($sformatf("dut%0d empty idle violations", i), bad[i], 0);

        // Single words, including the parity reference values.
        for (int i = 0; i < N; i++) begin rd0[i] = rd_cnt[i]; fr0[i] = frames_ok[i]; end
        push(9'h0A5);
        wait_idle("single A5");
        push(9'h007);
        wait_idle("single 07");
        for (int i = 0; i < N; i++) begin
            chk($sformatf("dut%0d single reads", i), rd_cnt[i] - rd0[i], 2);
            chk($sformatf("dut%0d single frames", i), frames_ok[i] - fr0[i], 2);
        end

        // Two words queued before enabling: back-to-back frames with a two-cycle gap.
        drive_en(1'b0);
        for (int i = 0; i < N; i++) begin rd0[i] = rd_cnt[i]; fr0[i] = frames_ok[i]; end
        push(9'h001);
        push(9'h080);
        repeat (4) @(negedge clk);
        drive_en(1'b1);
        wait_idle("back-to-back");
        for (int i = 0; i < N; i++) begin
            chk($sformatf("dut%0d b2b reads", i), rd_cnt[i] - rd0[i], 2);
            chk($sformatf("dut%0d b2b frames", i), frames_ok[i] - fr0[i], 2);
            chk($sformatf("dut%0d b2b gap", i), gap[i], 2);
        end

        // Reset in the middle of the data bits drops the frame without a re-read.
        for (int i = 0; i < N; i++) begin
            rd0[i] = rd_cnt[i]; fr0[i] = frames_ok[i]; dr0[i] = dropped[i];
        end
        push(9'($urandom));
        wait_start("reset frame");
        repeat (16) @(negedge clk);
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("dut%0d tx at reset", i), int'(tx_v[i]), 1);
            chk($sformatf("dut%0d busy at reset", i), int'(busy_v[i]), 0);
        end
        n = 0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (fd_v[i]) n++;
        end
        chk("frame_done during reset", n, 0);
        @(posedge clk);
        #2;
        nrst = 1'b1;
        for (int i = 0; i < N; i++) chk($sformatf("dut%0d dropped frames", i), dropped[i] - dr0[i], 1);
        push(9'($urandom));
        wait_idle("after reset");
        for (int i = 0; i < N; i++) begin
            chk($sformatf("dut%0d reset reads", i), rd_cnt[i] - rd0[i], 2);
            chk($sformatf("dut%0d reset frames", i), frames_ok[i] - fr0[i], 1);
        end

        // Dropping tx_en during START finishes the frame and holds off the next fetch.
        for (int i = 0; i < N; i++) begin rd0[i] = rd_cnt[i]; fr0[i] = frames_ok[i]; end
        push(9'($urandom));
        push(9'($urandom));
        wait_start("tx_en hold");
        drive_en(1'b0);
        repeat (80) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("dut%0d hold reads", i), rd_cnt[i] - rd0[i], 1);
            chk($sformatf("dut%0d hold frames", i), frames_ok[i] - fr0[i], 1);
            chk($sformatf("dut%0d hold busy", i), int'(busy_v[i]), 0);
            chk($sformatf("dut%0d hold fifo_valid", i), int'(fv_v[i]), 1);
        end
        drive_en(1'b1);
        wait_idle("tx_en resume");
        for (int i = 0; i < N; i++) begin
            chk($sformatf("dut%0d resume reads", i), rd_cnt[i] - rd0[i], 2);
            chk($sformatf("dut%0d resume frames", i), frames_ok[i] - fr0[i], 2);
        end

        // Random words with random spacing and tx_en toggling.
        for (int k = 0; k < 24; k++) begin
            push(9'($urandom));
            repeat ($urandom_range(0, 50)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) drive_en(~tx_en);
        end
        drive_en(1'b1);
        wait_idle("random");

        for (int i = 0; i < N; i++) begin
            chk($sformatf("dut%0d all words accounted", i), frames_ok[i] + dropped[i], plan.size());
            chk($sformatf("dut%0d total reads", i), rd_cnt[i], plan.size());
            chk($sformatf("dut%0d reads of empty fifo", i), rd_empty[i], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, nrst; all other logic SHALL be synchronous to the rising edge of clk.
REQ-002 The block SHALL have parameter WIDTH, default 8: data bits per frame, range 5..9.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, minimum 2.
REQ-004 The block SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-005 The block SHALL have parameter STOP_BITS, default 1: number of stop bits, 1 or 2.
REQ-006 The block SHALL have port clk, input, 1 bit: clock.
REQ-007 The block SHALL have port nrst, input, 1 bit: asynchronous reset, active low.
REQ-008 The block SHALL have port tx_en, input, 1 bit: permits starting a new frame.
REQ-009 The block SHALL have port fifo_valid, input, 1 bit: upstream FIFO holds at least one word.
REQ-010 The block SHALL have port fifo_data, input, WIDTH bits: upstream FIFO registered read data, valid the cycle after a read strobe.
REQ-011 The block SHALL have port fifo_rd_en, output, 1 bit: one-cycle read strobe to the FIFO.
REQ-012 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-013 The block SHALL have port busy, output, 1 bit: frame fetch or transmission in progress.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-015 The FSM states SHALL be IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
REQ-016 IDLE -> REQ SHALL occur when tx_en=1 and fifo_valid=1; otherwise the FSM SHALL remain in IDLE.
REQ-017 fifo_rd_en SHALL equal 1 only while state=REQ, and SHALL be decoded from registered state; REQ SHALL last one cycle, then LOAD.
REQ-018 In LOAD, which lasts one cycle, fifo_data SHALL be captured into the shift register and parity SHALL be computed from it; the FSM then goes to START.
REQ-019 START, each DATA bit, PARITY and each STOP bit SHALL each hold tx constant for exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on every state or bit change.
REQ-020 START SHALL drive tx=0.
REQ-021 DATA SHALL drive WIDTH bits LSB-first, with the bit index wrapping from WIDTH-1 to exit.
REQ-022 PARITY SHALL be entered only if PARITY!=0; it SHALL drive XOR of the data bits for even parity and its inverse for odd parity.
REQ-023 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-024 frame_done SHALL pulse for 1 cycle in the last cycle of STOP.
REQ-025 From the last STOP cycle, the next state SHALL be REQ if tx_en=1 and fifo_valid=1, else IDLE; the back-to-back inter-frame gap SHALL therefore be exactly 2 extra idle-high cycles (REQ, LOAD).
REQ-026 In IDLE, REQ and LOAD, tx SHALL be 1.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Deasserting tx_en mid-frame SHALL NOT abort the frame; it SHALL only block the next fetch.
REQ-029 fifo_valid dropping after REQ SHALL NOT affect the current frame.
REQ-030 fifo_data SHALL be ignored outside LOAD.
REQ-031 The frame length SHALL be (1+WIDTH+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles from START entry to STOP exit.
REQ-032 The baud counter width SHALL be $clog2(CLKS_PER_BIT) and the bit index width SHALL be $clog2(WIDTH); neither SHALL overflow.

Reset
REQ-033 On nrst=0, asynchronously and regardless of state: state=IDLE, tx=1, busy=0, fifo_rd_en=0, frame_done=0, counters=0, shift register=0.
REQ-034 A reset mid-frame SHALL drop the frame without re-read; the first cycle after reset release SHALL behave as IDLE.

Verification
REQ-035 WIDTH=8, CLKS_PER_BIT=4, PARITY=0, fifo_data=0xA5, one word -> one fifo_rd_en pulse; tx = 0,1,0,1,0,0,1,0,1,1, each 4 cycles; frame_done at cycle 40 after START; then IDLE.
REQ-036 PARITY=1 with 0x07 -> parity bit 1; PARITY=2 with 0x07 -> parity bit 0; frame length 44 cycles.
REQ-037 fifo_valid=0 with tx_en=1 for 100 cycles -> tx=1, busy=0, and fifo_rd_en never asserted.
REQ-038 Two words 0x01, 0x80 queued -> two frames with exactly 2 high cycles between the stop bit end and the second start bit; exactly two fifo_rd_en pulses.
REQ-039 nrst asserted during DATA bit 3 -> tx=1 and busy=0 immediately; no frame_done; the next fifo_valid starts a fresh frame.
REQ-040 tx_en cleared during START with fifo_valid=1 -> current frame completes; no further fifo_rd_en until tx_en returns to 1.
